// File: rtl/fetch_pc_unit_if.sv
// Instruction memory fetch handshake between the fetch front end and imem.
// The fetch side drives req/addr; memory answers with ready/rdata.
interface fetch_pc_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch front end: PC register, imem handshake, IF/ID register,
// one-entry stall buffer and redirect drain of in-flight fetches.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] predict_pc,
  input  logic        predict_do_branch,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  fetch_pc_unit_if.master imem,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_4,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_pred_taken,
  output logic [31:0] id_pred_pc
);

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        taken;
    logic [31:0] tgt;
  } slot_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] pending_pc, pending_n;
  slot_t       bufr, buf_n;
  slot_t       id_q, id_n;
  logic        idv_q, idv_n;

  logic [31:0] ppc, rpc;
  slot_t       fetched;
  logic        unused_low;

  // low address bits are forced to zero: pc stays word aligned
  assign ppc = {predict_pc[31:2], 2'b00};
  assign rpc = {redirect_pc[31:2], 2'b00};
  assign unused_low = ^{predict_pc[1:0], redirect_pc[1:0]};

  assign fetched = '{
    pc:    pc,
    inst:  imem.imem_rdata,
    taken: predict_do_branch,
    tgt:   ppc
  };

  assign imem.imem_req  = !rst && (state != HOLD);
  assign imem.imem_addr = pc;
  assign if_pc          = pc;
  assign if_pc_4        = pc + 32'd4;

  assign id_valid      = idv_q;
  assign id_pc         = id_q.pc;
  assign id_inst       = id_q.inst;
  assign id_pred_taken = id_q.taken;
  assign id_pred_pc    = id_q.tgt;

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    pending_n = pending_pc;
    buf_n     = bufr;
    id_n      = id_q;
    idv_n     = idv_q;
    if (redirect) begin
      idv_n      = 1'b0;
      id_n.inst  = NOP_INST;
      unique case (state)
        FETCH: begin
          if (imem.imem_ready) begin
            pc_n = rpc;
          end else begin
            pending_n = rpc;
            state_n   = DRAIN;
          end
        end
        DRAIN: begin
          pending_n = rpc;
          if (imem.imem_ready) begin
            pc_n    = rpc;
            state_n = FETCH;
          end
        end
        HOLD: begin
          pc_n    = rpc;
          state_n = FETCH;
        end
        default: state_n = FETCH;
      endcase
    end else begin
      unique case (state)
        FETCH: begin
          if (imem.imem_ready) begin
            pc_n = ppc;
            if (stall) begin
              buf_n   = fetched;
              state_n = HOLD;
            end else begin
              id_n  = fetched;
              idv_n = 1'b1;
            end
          end else if (!stall) begin
            idv_n = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            id_n    = bufr;
            idv_n   = 1'b1;
            state_n = FETCH;
          end
        end
        DRAIN: begin
          // the response belongs to the squashed path
          if (imem.imem_ready) begin
            pc_n    = pending_pc;
            state_n = FETCH;
          end
        end
        default: state_n = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      pending_pc <= '0;
      bufr       <= '0;
      id_q       <= '{pc: '0, inst: NOP_INST, taken: 1'b0, tgt: '0};
      idv_q      <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      pending_pc <= pending_n;
      bufr       <= buf_n;
      id_q       <= id_n;
      idv_q      <= idv_n;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed plan steps then random traffic,
// checked each cycle against a transaction-level fetch model.
module tb_fetch_pc_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        taken;
    logic [31:0] tgt;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] predict_pc;
  logic        predict_do_branch;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] if_pc, if_pc_4;
  logic        id_valid;
  logic [31:0] id_pc, id_inst, id_pred_pc;
  logic        id_pred_taken;

  fetch_pc_unit_if bus ();

  fetch_pc_unit dut (
    .clk               (clk),
    .rst               (rst),
    .predict_pc        (predict_pc),
    .predict_do_branch (predict_do_branch),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc),
    .stall             (stall),
    .imem              (bus),
    .if_pc             (if_pc),
    .if_pc_4           (if_pc_4),
    .id_valid          (id_valid),
    .id_pc             (id_pc),
    .id_inst           (id_inst),
    .id_pred_taken     (id_pred_taken),
    .id_pred_pc        (id_pred_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: next fetch address, squashed-fetch target, stalled instruction
  logic [31:0] m_pc;
  bit          m_drain;
  logic [31:0] m_target;
  ent_t        held[$];
  ent_t        m_id;
  bit          m_idv;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_5A13;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("imem_req", {31'd0, bus.imem_req},
        {31'd0, (rst !== 1'b1) && held.size() == 0});
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("if_pc", if_pc, m_pc);
    chk("if_pc_4", if_pc_4, m_pc + 32'd4);
    chk("id_valid", {31'd0, id_valid}, {31'd0, m_idv});
    chk("id_pc", id_pc, m_id.pc);
    chk("id_inst", id_inst, m_id.inst);
    chk("id_pred_taken", {31'd0, id_pred_taken}, {31'd0, m_id.taken});
    chk("id_pred_pc", id_pred_pc, m_id.tgt);
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_drain = 1'b0;
    m_target = 32'h0;
    held.delete();
    m_id    = '{pc: 32'h0, inst: NOP, taken: 1'b0, tgt: 32'h0};
    m_idv   = 1'b0;
  endtask

  task automatic model_step(input bit rd, input logic [31:0] rpc,
                            input bit st, input bit rdy, input bit tk,
                            input logic [31:0] ppc);
    logic [31:0] r, p;
    bit got;
    ent_t e;
    r = rpc & ~32'd3;
    p = ppc & ~32'd3;
    got = rdy && held.size() == 0;
    if (rd) begin
      m_idv = 1'b0;
      m_id.inst = NOP;
      if (held.size() != 0) begin
        held.delete();
        m_pc = r;
      end else if (m_drain || !got) begin
        m_target = r;
        m_drain = !got;
        if (got) m_pc = r;
      end else begin
        m_pc = r;
      end
    end else if (held.size() != 0) begin
      if (!st) begin
        m_id = held.pop_front();
        m_idv = 1'b1;
      end
    end else if (m_drain) begin
      if (got) begin
        m_pc = m_target;
        m_drain = 1'b0;
      end
    end else if (got) begin
      e = '{pc: m_pc, inst: mem(m_pc), taken: tk, tgt: p};
      if (st) held.push_back(e);
      else begin
        m_id = e;
        m_idv = 1'b1;
      end
      m_pc = p;
    end else if (!st) begin
      m_idv = 1'b0;
    end
  endtask

  task automatic cycle(input bit rd, input logic [31:0] rpc,
                       input bit st, input bit rdy, input bit tk,
                       input logic [31:0] ppc);
    redirect          = rd;
    redirect_pc       = rpc;
    stall             = st;
    bus.imem_ready    = rdy;
    bus.imem_rdata    = mem(m_pc);
    predict_do_branch = tk;
    predict_pc        = ppc;
    model_step(rd, rpc, st, rdy, tk, ppc);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) cycle(0, 32'h0, 0, 1, 0, m_pc + 32'd4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    stall = 1'b0;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'h0;
    predict_do_branch = 1'b0;
    predict_pc = 32'h0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] tgt;
    bit tk;
    @(negedge clk);
    do_reset();
    seq(2);
    cycle(0, 32'h0, 1, 1, 0, 32'hC);
    for (int i = 0; i < 3; i++) cycle(0, 32'h0, 1, 1'($urandom), 0, 32'h4);
    cycle(0, 32'h0, 0, 0, 0, 32'h0);
    seq(1);
    chk("pc_at_branch", m_pc, 32'h10);
    cycle(0, 32'h0, 0, 1, 1, 32'h40);
    cycle(1, 32'h20, 0, 1, 0, 32'h0);
    cycle(1, 32'h100, 0, 0, 0, 32'h24);
    cycle(0, 32'h0, 0, 0, 0, 32'h24);
    cycle(0, 32'h0, 0, 1, 0, 32'h24);
    seq(1);
    cycle(1, 32'h202, 1, 1, 0, 32'h108);
    cycle(0, 32'h0, 1, 1, 0, 32'h204);
    cycle(1, 32'h301, 1, 1, 0, 32'h0);
    cycle(1, 32'hFFFF_FFFF, 0, 1, 0, 32'h0);
    seq(3);
    cycle(0, 32'h0, 0, 0, 0, 32'h0);
    do_reset();
    seq(1);
    for (int i = 0; i < 600; i++) begin
      tk  = ($urandom_range(0, 3) == 0);
      tgt = tk ? $urandom() : ((m_pc + 32'd4) | 32'($urandom_range(0, 3)));
      cycle($urandom_range(0, 9) == 0, $urandom(),
            $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
            tk, tgt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
